// File: rtl/qmem_pkg.sv
// Shared definitions for the QMEM width bridges: FSM states, the half-word
// lane bit and the 16-to-32 byte-lane steering helper.
package qmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam int unsigned HW_LANE_BIT = 1;

   // Big-endian lanes: half-word 0 lives in the upper 16 bits of the word.
   function automatic logic [3:0] lane_sel(input logic i_hw, input logic [1:0] i_sel);
      return i_hw ? {2'b00, i_sel} : {i_sel, 2'b00};
   endfunction

endpackage

// File: rtl/qmem_rdbuf.sv
// One-word read buffer for qmem_bridge_up; only built when
// QMEM_BRIDGE_UP_RDBUF_EN is defined.
`ifdef QMEM_BRIDGE_UP_RDBUF_EN
module qmem_rdbuf #(
   parameter int unsigned WAW = 20
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [WAW-1:0] i_lookup_adr,
   input  logic           i_wr,
   input  logic           i_fill,
   input  logic [WAW-1:0] i_fill_adr,
   input  logic [31:0]    i_fill_data,
   input  logic           i_inval,
   output logic           o_hit,
   output logic [31:0]    o_data
);

   logic           r_valid;
   logic [WAW-1:0] r_adr;
   logic [31:0]    r_data;
   logic           w_match;

   assign w_match = r_valid && (r_adr == i_lookup_adr);
   assign o_hit   = w_match;
   assign o_data  = r_data;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the data word is reset too; it is one register, not a RAM, so clearing it is free.
      if (rst) begin
         r_valid <= 1'b0;
         r_adr   <= '0;
         r_data  <= '0;
      end else if (i_inval || (i_wr && w_match)) begin
         r_valid <= 1'b0;
      end else if (i_fill) begin
         r_valid <= 1'b1;
         r_adr   <= i_fill_adr;
         r_data  <= i_fill_data;
      end
   end

endmodule
`endif

// File: rtl/qmem_bridge_up.sv
// 16-bit QMEM master to 32-bit QMEM slave bridge, one slave access per request.
// Define QMEM_BRIDGE_UP_RDBUF_EN to add a one-word read buffer (qmem_rdbuf).
module qmem_bridge_up #(
   parameter int unsigned AW = 22
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] m_adr,
   input  logic          m_cs,
   input  logic          m_we,
   input  logic [1:0]    m_sel,
   input  logic [15:0]   m_dat_w,
   output logic [15:0]   m_dat_r,
   output logic          m_ack,
   output logic          m_err,
   output logic [AW-1:0] s_adr,
   output logic          s_cs,
   output logic          s_we,
   output logic [3:0]    s_sel,
   output logic [31:0]   s_dat_w,
   input  logic [31:0]   s_dat_r,
   input  logic          s_ack,
   input  logic          s_err
);

   import qmem_pkg::*;

   state_t        r_state,   w_state_nxt;
   logic [AW-1:0] r_s_adr,   w_s_adr_nxt;
   logic          r_s_cs,    w_s_cs_nxt;
   logic          r_s_we,    w_s_we_nxt;
   logic [3:0]    r_s_sel,   w_s_sel_nxt;
   logic [31:0]   r_s_dat_w, w_s_dat_w_nxt;
   logic [15:0]   r_m_dat_r, w_m_dat_r_nxt;
   logic          r_m_err,   w_m_err_nxt;
   logic          r_hw,      w_hw_nxt;

   logic          w_buf_hit;
   logic [31:0]   w_buf_data;
   logic [15:0]   w_buf_half;
   logic          w_unused;

   assign w_unused = m_adr[0];

`ifdef QMEM_BRIDGE_UP_RDBUF_EN
   localparam bit RDBUF_EN = 1'b1;

   logic w_buf_wr;
   logic w_buf_fill;
   logic w_buf_inval;

   assign w_buf_wr    = (r_state == ST_IDLE) && m_cs && m_we;
   assign w_buf_fill  = (r_state == ST_WAIT) && s_ack && !s_err && !r_s_we;
   assign w_buf_inval = (r_state == ST_WAIT) && s_err;

   qmem_rdbuf #(
      .WAW (AW-2)
   ) u_rdbuf (
      .clk          (clk),
      .rst          (rst),
      .i_lookup_adr (m_adr[AW-1:2]),
      .i_wr         (w_buf_wr),
      .i_fill       (w_buf_fill),
      .i_fill_adr   (r_s_adr[AW-1:2]),
      .i_fill_data  (s_dat_r),
      .i_inval      (w_buf_inval),
      .o_hit        (w_buf_hit),
      .o_data       (w_buf_data)
   );
`else
   localparam bit RDBUF_EN = 1'b0;

   assign w_buf_hit  = 1'b0;
   assign w_buf_data = '0;
`endif

   assign w_buf_half = m_adr[HW_LANE_BIT] ? w_buf_data[15:0] : w_buf_data[31:16];

   always_comb begin
      // NOTE: every next-value defaults to its register so no path infers a latch.
      w_state_nxt   = r_state;
      w_s_adr_nxt   = r_s_adr;
      w_s_cs_nxt    = r_s_cs;
      w_s_we_nxt    = r_s_we;
      w_s_sel_nxt   = r_s_sel;
      w_s_dat_w_nxt = r_s_dat_w;
      w_m_dat_r_nxt = r_m_dat_r;
      w_m_err_nxt   = r_m_err;
      w_hw_nxt      = r_hw;

      unique case (r_state)
         ST_IDLE: begin
            if (m_cs) begin
               if (!m_we && w_buf_hit) begin
                  w_m_dat_r_nxt = w_buf_half;
                  w_m_err_nxt   = 1'b0;
                  w_state_nxt   = ST_ACK;
               end else begin
                  w_s_adr_nxt   = {m_adr[AW-1:2], 2'b00};
                  w_s_we_nxt    = m_we;
                  w_s_sel_nxt   = (RDBUF_EN && !m_we) ? 4'hF
                                                      : lane_sel(m_adr[HW_LANE_BIT], m_sel);
                  w_s_dat_w_nxt = {m_dat_w, m_dat_w};
                  w_hw_nxt      = m_adr[HW_LANE_BIT];
                  w_s_cs_nxt    = 1'b1;
                  w_state_nxt   = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (s_ack || s_err) begin
               w_s_cs_nxt    = 1'b0;
               w_m_err_nxt   = s_err;
               w_m_dat_r_nxt = s_err ? 16'h0000 : (r_hw ? s_dat_r[15:0] : s_dat_r[31:16]);
               w_state_nxt   = ST_ACK;
            end
         end
         ST_ACK:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments so each register samples pre-edge values.
      if (rst) begin
         r_state   <= ST_IDLE;
         r_s_adr   <= '0;
         r_s_cs    <= 1'b0;
         r_s_we    <= 1'b0;
         r_s_sel   <= '0;
         r_s_dat_w <= '0;
         r_m_dat_r <= '0;
         r_m_err   <= 1'b0;
         r_hw      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_s_adr   <= w_s_adr_nxt;
         r_s_cs    <= w_s_cs_nxt;
         r_s_we    <= w_s_we_nxt;
         r_s_sel   <= w_s_sel_nxt;
         r_s_dat_w <= w_s_dat_w_nxt;
         r_m_dat_r <= w_m_dat_r_nxt;
         r_m_err   <= w_m_err_nxt;
         r_hw      <= w_hw_nxt;
      end
   end

   assign m_ack   = (r_state == ST_ACK);
   assign m_err   = m_ack && r_m_err;
   assign m_dat_r = r_m_dat_r;
   assign s_adr   = r_s_adr;
   assign s_cs    = r_s_cs;
   assign s_we    = r_s_we;
   assign s_sel   = r_s_sel;
   assign s_dat_w = r_s_dat_w;

endmodule

// File: doc/qmem_bridge_up.md
# qmem_bridge_up

Synchronous QMEM width bridge: a 16-bit QMEM master accesses a 32-bit QMEM slave on the same clock. It is the counterpart to the 32-to-16 async bridge. Each 16-bit access becomes exactly one 32-bit slave access with byte-lane steering. Read data is returned from the addressed half-word. An optional read buffer serves the second half-word of a just-read 32-bit word without a slave access.

## Interface
- AW, 22, byte address width, both sides
- MDW, 16, master data width (fixed)
- MSW, 2, master byte selects (fixed)
- SDW, 32, slave data width (fixed)
- SSW, 4, slave byte selects (fixed)

Ports:
- clk  in  1  bridge clock, both sides
- rst  in  1  asynchronous, active-high reset
- m_adr  in  AW  master byte address
- m_cs  in  1  master request; held until m_ack
- m_we  in  1  write enable
- m_sel  in  2  byte selects, [1] = high byte
- m_dat_w  in  16  write data
- m_dat_r  out  16  read data, valid in m_ack cycle
- m_ack  out  1  one-cycle completion pulse
- m_err  out  1  error, coincident with m_ack
- s_adr  out  AW  word-aligned slave address
- s_cs  out  1  slave request
- s_we  out  1  slave write enable
- s_sel  out  4  slave byte selects
- s_dat_w  out  32  slave write data
- s_dat_r  in  32  slave read data, valid with s_ack
- s_ack  in  1  slave completion
- s_err  in  1  slave error; terminates the access like s_ack

## Operation
- States: IDLE, WAIT, ACK.
- IDLE, m_cs=1: latch the request.
  - s_adr = {m_adr[AW-1:2],2'b00}; s_we = m_we; s_dat_w = {m_dat_w,m_dat_w}.
  - Big-endian lanes. m_adr[1]=0 selects upper lanes: s_sel = {m_sel,2'b00}. m_adr[1]=1 gives s_sel = {2'b00,m_sel}.
  - s_cs=1, go to WAIT.
- WAIT: s_cs, s_adr, s_sel, s_we and s_dat_w stay stable.
  - On s_ack or s_err: s_cs=0, register the addressed half of s_dat_r into m_dat_r, go to ACK.
  - Upper half for m_adr[1]=0, lower half for m_adr[1]=1.
  - On s_err: m_err=1 and m_dat_r=16'h0000.
  - If s_ack and s_err are both high, s_err wins.
- ACK: m_ack=1 for exactly one cycle; m_cs is ignored in this cycle; go to IDLE.
- The master drops m_cs, or presents the next request, in the cycle after m_ack. A back-to-back request is accepted in IDLE on that cycle.
- Write data is replicated to both halves; s_sel alone qualifies the lanes.
- m_sel=2'b00 is still forwarded as one slave access with s_sel=4'b0000.

## Timing
- Reset (async, immediate) values:
  - s_cs, s_we, m_ack, m_err = 0
  - s_adr, s_sel, s_dat_w, m_dat_r = 0
  - state = IDLE; read buffer invalid
- Reset during WAIT drops s_cs at once and abandons the cycle. The slave must tolerate this.
- Latency:
  - m_cs sampled at edge N gives s_cs high from N+1.
  - s_ack sampled at edge K gives m_ack high during K+1 to K+2.
  - Minimum m_cs to m_ack: 2 cycles.
- m_dat_r holds its value until the next completion.

## Configuration
- QMEM_BRIDGE_UP_RDBUF_EN defined:
  - Reads are issued with s_sel=4'hF.
  - A successful read stores the word address and the full s_dat_r, and sets the buffer valid.
  - A read in IDLE whose word address matches the valid buffer is a hit. A hit skips the slave: IDLE goes straight to ACK, m_dat_r is taken from the buffer, and latency is 1 cycle.
  - Invalidate the buffer on a write to the buffered word, on s_err, and on reset.
  - The buffer is not coherent with other slave masters.
- Undefined: no buffer; every access goes to the slave with lane-derived s_sel.

## Structure
- Shared package qmem_pkg holds:
  - the state encodings (IDLE/WAIT/ACK)
  - the half-word lane index constant (address bit 1)
  - the lane-select helper mapping {m_adr[1], m_sel} to s_sel
- Sub-module qmem_rdbuf, under QMEM_BRIDGE_UP_RDBUF_EN, provides address/data/valid registers, hit compare and invalidate logic.

## Test plan
- Write: m_adr=0x000002, m_sel=2'b11, m_dat_w=0xBEEF, slave acks 3 cycles after s_cs -> s_adr=0x000000, s_sel=4'b0011, s_dat_w=0xBEEFBEEF, s_we=1; m_ack one cycle, one cycle after s_ack.
- Read m_adr=0x000004 then 0x000006, slave returns 0x12345678 -> m_dat_r=0x1234 then 0x5678.
  - With RDBUF: the second read makes no s_cs and m_ack comes 1 cycle after m_cs is sampled.
- Byte read m_adr=0x000000, m_sel=2'b10 without RDBUF -> s_sel=4'b1000.
- Read with s_err=1 (s_dat_r=0xFFFFFFFF) -> m_ack and m_err high one cycle, m_dat_r=0x0000.
  - With RDBUF: an immediate re-read goes to the slave.
- With RDBUF: read 0x000008, write 0x00000A, then read 0x000008 -> the final read issues s_cs.
- Assert rst during WAIT -> s_cs=0 and m_ack=0 at once; after release, a read at 0x000010 completes normally in 2 cycles with a zero-wait slave.
